counter_sequencer: RTL and testbench

Command-driven controller that sequences a WIDTH-bit up/down counter datapath. It accepts START/STOP/LOAD/CLEAR commands over a valid/ready handshake, runs the counter toward a programmed terminal value with modulo wrap-around, and reports completion with a one-cycle `done` pulse. It sits between a host or test-control FSM and the counter datapath, replacing free-running counting with bounded, restartable runs.

---
 rtl/counter_seq_pkg.sv | 15 +
 rtl/updown_counter.sv | 46 ++++
 rtl/counter_sequencer.sv | 130 +++++++++++++
 tb/tb_counter_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared opcodes and FSM state encoding for the counter sequencer.
package counter_seq_pkg;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/updown_counter.sv
// WIDTH-bit up/down counter datapath with synchronous load; load wins over enable.
module updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load, else step in the requested direction, else hold.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (dir) begin
                count_d = count_q - ONE;
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven FSM that runs the up/down counter toward a terminal value
// and reports completion with a one-cycle done pulse.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             cnt_en_s;
    logic             cnt_load_s;
    logic [WIDTH-1:0] cnt_load_val_s;
    logic             accept_s;

    assign cmd_ready = (state_q != ST_DONE);
    assign accept_s  = cmd_valid && cmd_ready;

    // Next-state, datapath control and pulse generation.
    always_comb begin
        state_d        = state_q;
        term_d         = term_q;
        dir_d          = dir_q;
        done_d         = 1'b0;
        err_d          = 1'b0;
        cnt_en_s       = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_START: begin
                            term_d  = cmd_data;
                            dir_d   = cmd_dir;
                            state_d = ST_RUN;
                        end
                        OP_LOAD: begin
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = cmd_data;
                        end
                        OP_CLEAR: begin
                            cnt_load_s     = 1'b1;
                            cnt_load_val_s = {WIDTH{1'b0}};
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && (cmd_op == OP_CLEAR)) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = {WIDTH{1'b0}};
                    state_d        = ST_IDLE;
                end else if (accept_s && (cmd_op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end else begin
                    // START/LOAD are dropped but the run carries on.
                    err_d = accept_s && ((cmd_op == OP_START) || (cmd_op == OP_LOAD));
                    if (count == term_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, run parameters and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            term_q  <= {WIDTH{1'b0}};
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (cnt_en_s),
        .dir      (dir_q),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .count    (count)
    );

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed plus randomized bench for counter_sequencer against a step-count reference model.
module tb_counter_sequencer;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         cmd_dir;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         cmd_err;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: mode 0 idle, 1 running, 2 finishing; m_left = steps still to take.
    int m_mode, m_count, m_left, m_dir;
    bit m_done, m_err;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_count = 0;
        m_left  = 0;
        m_dir   = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_edge(input bit v, input int op, input int data, input int dir);
        bit acc;
        acc    = v && (m_mode != 2);
        m_done = 1'b0;
        m_err  = 1'b0;
        case (m_mode)
            0: begin
                if (acc && op == 0) begin
                    m_dir  = dir;
                    m_left = dir ? ((m_count - data) & (MOD - 1)) : ((data - m_count) & (MOD - 1));
                    m_mode = 1;
                end else if (acc && op == 2) begin
                    m_count = data;
                end else if (acc && op == 3) begin
                    m_count = 0;
                end
            end
            1: begin
                if (acc && op == 3) begin
                    m_count = 0;
                    m_mode  = 0;
                end else if (acc && op == 1) begin
                    m_mode = 0;
                end else begin
                    m_err = acc && (op == 0 || op == 2);
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_done = 1'b1;
                    end else begin
                        m_count = (m_count + (m_dir != 0 ? MOD - 1 : 1)) % MOD;
                        m_left--;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endfunction

    task automatic check_outputs();
        check_eq("count",     32'(count),     32'(m_count));
        check_eq("busy",      32'(busy),      32'(m_mode == 1));
        check_eq("done",      32'(done),      32'(m_done));
        check_eq("cmd_err",   32'(cmd_err),   32'(m_err));
        check_eq("cmd_ready", 32'(cmd_ready), 32'(m_mode != 2));
    endtask

    task automatic apply(input bit v, input logic [1:0] op, input logic [W-1:0] data, input bit dir);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = data;
        cmd_dir   = dir;
        @(posedge clk);
        model_edge(v, int'(op), int'(data), int'(dir));
        #1;
        check_outputs();
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 2'b00, 4'd0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'd0;
        cmd_dir   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Basic run: 3 -> 6 up
        apply(1'b1, 2'b10, 4'd3, 1'b0);
        apply(1'b1, 2'b00, 4'd6, 1'b0);
        idle(6);

        // Wrap up and down
        apply(1'b1, 2'b10, 4'd14, 1'b0);
        apply(1'b1, 2'b00, 4'd1, 1'b0);
        idle(5);
        apply(1'b1, 2'b10, 4'd1, 1'b0);
        apply(1'b1, 2'b00, 4'd14, 1'b1);
        idle(5);

        // Zero-distance run
        apply(1'b1, 2'b10, 4'd9, 1'b0);
        apply(1'b1, 2'b00, 4'd9, 1'b0);
        idle(3);

        // STOP mid-run at count 4
        apply(1'b1, 2'b10, 4'd0, 1'b0);
        apply(1'b1, 2'b00, 4'd10, 1'b0);
        for (int i = 0; i < 20 && m_count != 4; i++) idle(1);
        apply(1'b1, 2'b01, 4'd0, 1'b0);
        idle(2);

        // STOP on the edge where count equals term
        apply(1'b1, 2'b10, 4'd0, 1'b0);
        apply(1'b1, 2'b00, 4'd2, 1'b0);
        idle(2);
        apply(1'b1, 2'b01, 4'd0, 1'b0);
        idle(2);

        // Dropped LOAD, then CLEAR in RUN
        apply(1'b1, 2'b10, 4'd0, 1'b0);
        apply(1'b1, 2'b00, 4'd12, 1'b0);
        idle(2);
        apply(1'b1, 2'b10, 4'd7, 1'b0);
        idle(1);
        apply(1'b1, 2'b11, 4'd0, 1'b0);
        idle(2);

        // Asynchronous reset mid-run
        apply(1'b1, 2'b10, 4'd0, 1'b0);
        apply(1'b1, 2'b00, 4'd15, 1'b0);
        idle(3);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (5) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        #1;
        check_outputs();

        // Randomized traffic; commands sparse during runs so some complete
        for (int i = 0; i < 1500; i++) begin
            bit v;
            v = (m_mode == 1) ? ($urandom_range(5) == 0) : ($urandom_range(1) == 1);
            apply(v, 2'($urandom_range(3)), W'($urandom_range(MOD - 1)), 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
